// File: rtl/shot_clock_ctrl.sv
// Shot clock controller: edge-detected Start/Pause/Load controls, 1 s prescaler,
// countdown with expiry buzzer and registered two-digit 7-segment outputs.
module shot_clock_ctrl #(
    parameter int unsigned DIV      = 12000000,
    parameter int unsigned BUZZ_SEC = 2,
    parameter int unsigned LONG     = 24,
    parameter int unsigned SHORT    = 14
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Pause,
    input  logic       Load24,
    input  logic       Load14,
    output logic [4:0] Time,
    output logic [8:0] Seg1,
    output logic [8:0] Seg2,
    output logic       Running,
    output logic       Buzzer
);

    localparam int unsigned BUZZ_CYC = BUZZ_SEC * DIV;
    localparam int unsigned PRESC_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BCNT_W   = (BUZZ_CYC > 1) ? $clog2(BUZZ_CYC) : 1;

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(DIV - 1);
    localparam logic [BCNT_W-1:0]  BCNT_MAX  = BCNT_W'(BUZZ_CYC - 1);
    localparam logic [4:0]         LONG_T    = 5'(LONG);
    localparam logic [4:0]         SHORT_T   = 5'(SHORT);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    state_t               state_q, state_d;
    logic [4:0]           time_q, time_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
    logic                 buzz_q, buzz_d;
    logic [8:0]           seg1_q, seg1_d;
    logic [8:0]           seg2_q, seg2_d;
    logic                 start_q, pause_q, l24_q, l14_q;

    logic raw_start, raw_pause, raw_l24, raw_l14;
    logic ev_start, ev_pause, ev_l24, ev_l14;
    logic tick;

    function automatic logic [8:0] seg_code(input logic [4:0] d);
        case (d)
            5'd0:    seg_code = 9'h03F;
            5'd1:    seg_code = 9'h006;
            5'd2:    seg_code = 9'h05B;
            5'd3:    seg_code = 9'h04F;
            5'd4:    seg_code = 9'h066;
            5'd5:    seg_code = 9'h06D;
            5'd6:    seg_code = 9'h07D;
            5'd7:    seg_code = 9'h007;
            5'd8:    seg_code = 9'h07F;
            5'd9:    seg_code = 9'h06F;
            default: seg_code = 9'h000;
        endcase
    endfunction

    assign raw_start = Start  & ~start_q;
    assign raw_pause = Pause  & ~pause_q;
    assign raw_l24   = Load24 & ~l24_q;
    assign raw_l14   = Load14 & ~l14_q;

    // Only the highest-priority event of a cycle survives.
    assign ev_l24   = raw_l24;
    assign ev_l14   = raw_l14 & ~raw_l24;
    assign ev_pause = raw_pause & ~raw_l24 & ~raw_l14;
    assign ev_start = raw_start & ~raw_pause & ~raw_l24 & ~raw_l14;

    assign tick = (state_q == RUN) && (presc_q == PRESC_MAX);

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        presc_d = presc_q;
        bcnt_d  = bcnt_q;
        buzz_d  = buzz_q;
        seg1_d  = seg_code(time_q / 5'd10);
        seg2_d  = seg_code(time_q % 5'd10);

        if (ev_l24 || ev_l14) begin
            time_d  = ev_l24 ? LONG_T : SHORT_T;
            presc_d = '0;
            bcnt_d  = '0;
            buzz_d  = 1'b0;
            if (state_q == EXPIRED) state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    presc_d = '0;
                    if (ev_start) state_d = RUN;
                end
                RUN: begin
                    // A pause swallows a coincident tick; the prescaler holds DIV-1.
                    if (ev_pause) begin
                        state_d = PAUSED;
                    end else if (tick) begin
                        presc_d = '0;
                        if (time_q > 5'd1) begin
                            time_d = time_q - 5'd1;
                        end else begin
                            time_d  = 5'd0;
                            state_d = EXPIRED;
                            buzz_d  = 1'b1;
                            bcnt_d  = '0;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                PAUSED: begin
                    if (ev_start) state_d = RUN;
                end
                EXPIRED: begin
                    presc_d = '0;
                    if (buzz_q) begin
                        if (bcnt_q == BCNT_MAX) buzz_d = 1'b0;
                        else                    bcnt_d = bcnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            time_q  <= LONG_T;
            presc_q <= '0;
            bcnt_q  <= '0;
            buzz_q  <= 1'b0;
            seg1_q  <= seg_code(LONG_T / 5'd10);
            seg2_q  <= seg_code(LONG_T % 5'd10);
            start_q <= 1'b0;
            pause_q <= 1'b0;
            l24_q   <= 1'b0;
            l14_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            presc_q <= presc_d;
            bcnt_q  <= bcnt_d;
            buzz_q  <= buzz_d;
            seg1_q  <= seg1_d;
            seg2_q  <= seg2_d;
            start_q <= Start;
            pause_q <= Pause;
            l24_q   <= Load24;
            l14_q   <= Load14;
        end
    end

    assign Time    = time_q;
    assign Seg1    = seg1_q;
    assign Seg2    = seg2_q;
    assign Running = (state_q == RUN);
    assign Buzzer  = buzz_q;

endmodule

// File: tb/tb_shot_clock_ctrl.sv
// Directed bench for shot_clock_ctrl with DIV=4, BUZZ_SEC=2.
module tb_shot_clock_ctrl;

    logic       CLK = 1'b0;
    logic       Reset, Start, Pause, Load24, Load14;
    logic [4:0] Time;
    logic [8:0] Seg1, Seg2;
    logic       Running, Buzzer;

    int n_checks = 0;
    int n_errors = 0;
    int ones;

    shot_clock_ctrl #(.DIV(4), .BUZZ_SEC(2), .LONG(24), .SHORT(14)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .Pause(Pause),
        .Load24(Load24), .Load14(Load14), .Time(Time), .Seg1(Seg1),
        .Seg2(Seg2), .Running(Running), .Buzzer(Buzzer)
    );

    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Pause = 1'b0; Load24 = 1'b0; Load14 = 1'b0;
        step(2);
        chk("rst_time", Time, 24);
        chk("rst_seg1", Seg1, 9'h05B);
        chk("rst_seg2", Seg2, 9'h066);
        chk("rst_run", Running, 0);
        chk("rst_buzz", Buzzer, 0);
        Reset = 1'b0;
        step(1);

        // Start and first decrement
        Start = 1'b1; step(1);
        chk("start_run", Running, 1);
        Start = 1'b0;
        step(3);
        chk("pre_tick_time", Time, 24);
        step(1);
        chk("first_dec", Time, 23);
        step(1);
        chk("dec_seg1", Seg1, 9'h05B);
        chk("dec_seg2", Seg2, 9'h04F);

        // Pause at 17 with prescaler at 1, resume later
        step(24);
        chk("at17", Time, 17);
        Pause = 1'b1; step(1);
        chk("pause_run", Running, 0);
        Pause = 1'b0;
        step(20);
        chk("paused_time", Time, 17);
        chk("paused_run", Running, 0);
        Start = 1'b1; step(1);
        chk("resume_run", Running, 1);
        Start = 1'b0;
        step(2);
        chk("resume_hold", Time, 17);
        step(1);
        chk("resume_dec", Time, 16);

        // Load14 in RUN at 5
        step(44);
        chk("at5", Time, 5);
        Load14 = 1'b1; step(1);
        chk("l14_time", Time, 14);
        chk("l14_run", Running, 1);
        Load14 = 1'b0;
        step(1);
        chk("l14_seg1", Seg1, 9'h006);
        chk("l14_seg2", Seg2, 9'h066);
        step(2);
        chk("l14_hold", Time, 14);
        step(1);
        chk("l14_dec", Time, 13);

        // Load24 and Pause together: load wins, stays RUN
        Load24 = 1'b1; Pause = 1'b1; step(1);
        chk("l24p_time", Time, 24);
        chk("l24p_run", Running, 1);
        Load24 = 1'b0; Pause = 1'b0;

        // Run down to expiry
        step(95);
        chk("at1", Time, 1);
        chk("at1_buzz", Buzzer, 0);
        step(1);
        chk("exp_time", Time, 0);
        chk("exp_run", Running, 0);
        chk("exp_buzz", Buzzer, 1);
        ones = int'(Buzzer);
        Start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (i == 0) begin
                Start = 1'b0;
                chk("exp_start_ign", Running, 0);
            end
            ones += int'(Buzzer);
        end
        chk("buzz_len", ones, 8);
        chk("exp_hold_time", Time, 0);
        chk("exp_hold_run", Running, 0);

        // Load in EXPIRED returns to IDLE
        Load24 = 1'b1; step(1);
        chk("exp_l24_time", Time, 24);
        chk("exp_l24_run", Running, 0);
        chk("exp_l24_buzz", Buzzer, 0);
        Load24 = 1'b0;
        step(1);

        // Reset during buzzer
        Start = 1'b1; step(1);
        chk("run2", Running, 1);
        Start = 1'b0;
        step(97);
        chk("buzz2", Buzzer, 1);
        chk("buzz2_time", Time, 0);
        Reset = 1'b1; step(1);
        chk("rst_mid_buzz", Buzzer, 0);
        chk("rst_mid_time", Time, 24);
        chk("rst_mid_run", Running, 0);
        chk("rst_mid_seg1", Seg1, 9'h05B);
        chk("rst_mid_seg2", Seg2, 9'h066);
        Reset = 1'b0;
        step(1);
        Start = 1'b1; step(1);
        chk("post_rst_start", Running, 1);
        Start = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shot_clock_ctrl.md
SHOT_CLOCK_CTRL -- requirements
Module: shot_clock_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 12000000, meaning CLK cycles per one-second tick.
REQ-002 SHALL have parameter BUZZ_SEC, default 2, meaning buzzer duration in seconds (ticks).
REQ-003 SHALL have parameter LONG, default 24, meaning the full-period load value (1..29).
REQ-004 SHALL have parameter SHORT, default 14, meaning the short-period load value (1..29).
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port Start, input, 1 bit: level input whose rising edge means start or resume.
REQ-008 SHALL have port Pause, input, 1 bit: level input whose rising edge means pause.
REQ-009 SHALL have port Load24, input, 1 bit: level input whose rising edge means reload LONG.
REQ-010 SHALL have port Load14, input, 1 bit: level input whose rising edge means reload SHORT.
REQ-011 SHALL have port Time, output, 5 bits: current remaining seconds, binary.
REQ-012 SHALL have port Seg1, output, 9 bits: tens-digit segment code, with bit 8 (DP) always 0.
REQ-013 SHALL have port Seg2, output, 9 bits: ones-digit segment code, with bit 8 (DP) always 0.
REQ-014 SHALL have port Running, output, 1 bit: high iff the state is RUN.
REQ-015 SHALL have port Buzzer, output, 1 bit: expiry alarm, active-high.

Function
REQ-016 SHALL detect events as rising edges: event = input high now AND the registered previous sample low; an event is a 1-cycle internal pulse.
REQ-017 SHALL implement the FSM states IDLE, RUN, PAUSED and EXPIRED.
REQ-018 SHALL apply event priority Load24 > Load14 > Pause > Start; only the highest-priority event in a cycle takes effect, and the rest are discarded.
REQ-019 SHALL, on a Load event in any state, set Time to LONG (Load24) or SHORT (Load14), clear the prescaler, and clear Buzzer and the buzzer counter.
REQ-020 SHALL, on a Load event, keep RUN as RUN, PAUSED as PAUSED and IDLE as IDLE, and move EXPIRED to IDLE.
REQ-021 SHALL, on a Start event, move IDLE to RUN and PAUSED to RUN; Start SHALL be ignored in RUN and EXPIRED.
REQ-022 SHALL, on a Pause event, move RUN to PAUSED; Pause SHALL be ignored in every other state.
REQ-023 SHALL run the prescaler 0..DIV-1 only in RUN, hold it in PAUSED, and clear it in IDLE and EXPIRED.
REQ-024 SHALL define a tick as the RUN cycle in which the prescaler equals DIV-1; the prescaler then wraps to 0.
REQ-025 SHALL, on a tick with Time>1, decrement Time by 1.
REQ-026 SHALL, on a tick with Time==1, set Time to 0, enter EXPIRED, and set Buzzer to 1 in the next cycle.
REQ-027 SHALL, when a Pause or Load event coincides with a tick, discard the tick: with Pause, Time is unchanged and the prescaler holds DIV-1, so the tick fires on the first RUN cycle after resume; with Load, REQ-019 applies.
REQ-028 SHALL, in EXPIRED, hold Buzzer high for exactly BUZZ_SEC*DIV cycles, then low, with Time held at 0 until a Load event.
REQ-029 SHALL never let Time underflow below 0 or exceed the loaded value.
REQ-030 SHALL register Seg1/Seg2 so they reflect Time one cycle later: Seg1 = code(Time/10), Seg2 = code(Time%10).
REQ-031 SHALL use the segment codes 0..9 = 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F (hex).
REQ-032 SHALL size the prescaler to hold DIV-1 and the buzzer counter to hold BUZZ_SEC*DIV-1, with no truncation.
REQ-033 SHALL update Running in the same cycle as the state register.

Reset
REQ-034 SHALL, with Reset high at a CLK edge, set state=IDLE, Time=LONG, prescaler=0, buzzer counter=0, Buzzer=0, Running=0 and edge registers=0.
REQ-035 SHALL, with Reset high at a CLK edge, set Seg1=5B and Seg2=66 for the default LONG=24.
REQ-036 SHALL let Reset dominate all events and ticks, including mid-RUN and mid-buzz.

Verification (DIV=4, BUZZ_SEC=2)
REQ-037 SHALL cover: reset, then Start pulse -> Running=1 the next cycle; Time 24->23 four cycles after RUN entry; Seg1=5B, Seg2=4F one cycle later.
REQ-038 SHALL cover: running from 24 to 0 -> EXPIRED, Running=0, Buzzer high exactly 8 cycles, Time stays 0; a Start pulse there has no effect.
REQ-039 SHALL cover: Pause at Time=17, wait 20 cycles, then Start -> Time stays 17 while PAUSED; after resume, the decrement lands on the remaining prescaler count.
REQ-040 SHALL cover: Load14 in RUN at Time=5 -> Time=14, Seg1=06, Seg2=66, Running stays 1, next decrement 4 cycles later.
REQ-041 SHALL cover: Load24 and Pause rising in the same cycle in RUN -> Time=24 and state remains RUN.
REQ-042 SHALL cover: Reset high during the buzzer in EXPIRED -> next cycle IDLE, Buzzer=0, Time=24.
